// File: rtl/sd_audio_dac.sv
`default_nettype none
// ============================================================================
// Module   : sd_audio_dac
// Brief    : Stereo PCM output stage with mute ramp, shift attenuation and
//            first-order delta-sigma modulation onto two 1-bit audio pins.
// Revision : 1.0  initial release
// ============================================================================
module sd_audio_dac #(
  parameter int C_RAMP_DIV = 1024
) (
  input  logic        Bus2IP_Clk,
  input  logic        Bus2IP_Resetn,
  input  logic [15:0] Sample_left,
  input  logic [15:0] Sample_right,
  input  logic        Sample_valid,
  output logic        Sample_ready,
  input  logic        Mute,
  input  logic [3:0]  Volume,
  output logic        Audio_left,
  output logic        Audio_right,
  output logic        Muted
);

  localparam int                 c_CNT_W      = (C_RAMP_DIV > 2) ? $clog2(C_RAMP_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(C_RAMP_DIV - 1);
  localparam logic [8:0]         c_GAIN_UNITY = 9'd256;
  localparam logic [15:0]        c_U_SILENCE  = 16'h8000;

  logic               r_ready;
  logic [15:0]        r_hold_l;
  logic [15:0]        r_hold_r;
  logic [15:0]        r_act_l;
  logic [15:0]        r_act_r;
  logic [c_CNT_W-1:0] r_ramp_cnt;
  logic [8:0]         r_gain;
  logic [15:0]        r_u_l;
  logic [15:0]        r_u_r;
  logic [16:0]        r_acc_l;
  logic [16:0]        r_acc_r;
  logic               w_tc;

  // Gain scale, attenuation shift and conversion to offset binary.
  function automatic logic [15:0] f_scale(input logic [15:0] smp,
                                          input logic [8:0]  gain,
                                          input logic [3:0]  vol);
    logic signed [24:0] a;
    logic signed [24:0] g;
    logic signed [24:0] p;
    logic signed [15:0] s;
    logic signed [15:0] v;
    a = {{9{smp[15]}}, smp};
    g = {16'd0, gain};
    p = a * g;
    s = 16'(p >>> 8);
    v = s >>> vol;
    return v ^ 16'h8000;
  endfunction

  // Two-phase handshake: accept into hold, then publish to active next edge.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      r_ready  <= 1'b1;
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_act_l  <= '0;
      r_act_r  <= '0;
    end else if (r_ready) begin
      if (Sample_valid) begin
        r_hold_l <= Sample_left;
        r_hold_r <= Sample_right;
        r_ready  <= 1'b0;
      end
    end else begin
      r_act_l <= r_hold_l;
      r_act_r <= r_hold_r;
      r_ready <= 1'b1;
    end
  end

  assign w_tc = (r_ramp_cnt == c_CNT_LAST);

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      r_ramp_cnt <= '0;
      r_gain     <= '0;
    end else begin
      r_ramp_cnt <= w_tc ? '0 : r_ramp_cnt + 1'b1;
      if (w_tc) begin
        if (Mute && (r_gain != 9'd0)) begin
          r_gain <= r_gain - 9'd1;
        end else if (!Mute && (r_gain != c_GAIN_UNITY)) begin
          r_gain <= r_gain + 9'd1;
        end
      end
    end
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      r_u_l   <= c_U_SILENCE;
      r_u_r   <= c_U_SILENCE;
      r_acc_l <= '0;
      r_acc_r <= '0;
    end else begin
      r_u_l   <= f_scale(r_act_l, r_gain, Volume);
      r_u_r   <= f_scale(r_act_r, r_gain, Volume);
      // Carry out of the 16-bit sum is the output bit; it is dropped next cycle.
      r_acc_l <= {1'b0, r_acc_l[15:0]} + {1'b0, r_u_l};
      r_acc_r <= {1'b0, r_acc_r[15:0]} + {1'b0, r_u_r};
    end
  end

  assign Sample_ready = r_ready;
  assign Audio_left   = r_acc_l[16];
  assign Audio_right  = r_acc_r[16];
  assign Muted        = (r_gain == 9'd0);

endmodule
`default_nettype wire

// File: tb/tb_sd_audio_dac.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_audio_dac
// Brief    : Directed self-checking bench for sd_audio_dac (C_RAMP_DIV = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_sd_audio_dac;

  logic        clk;
  logic        rst_n;
  logic [15:0] sl;
  logic [15:0] sr;
  logic        valid;
  logic        ready;
  logic        mute;
  logic [3:0]  vol;
  logic        al;
  logic        ar;
  logic        muted;

  int errors = 0;
  int checks = 0;

  sd_audio_dac #(.C_RAMP_DIV(4)) dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Resetn (rst_n),
    .Sample_left   (sl),
    .Sample_right  (sr),
    .Sample_valid  (valid),
    .Sample_ready  (ready),
    .Mute          (mute),
    .Volume        (vol),
    .Audio_left    (al),
    .Audio_right   (ar),
    .Muted         (muted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    int n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready=%b, required 1", ready);
    end
    sl    = l;
    sr    = r;
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b1; mute = 1'b0; vol = 4'd0; sl = 16'h0; sr = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1 || al !== 1'b0 || ar !== 1'b0 || muted !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: ready=%b left=%b right=%b muted=%b, required 1 0 0 1",
               ready, al, ar, muted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        valid = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL first_accept: ready=%b, required 0", ready);
        end
      end
      if (k == 2) begin
        checks++;
        if (ready !== 1'b1) begin
          errors++;
          $display("FAIL ready_return: ready=%b, required 1", ready);
        end
      end
      checks++;
      if (muted !== (k < 4)) begin
        errors++;
        $display("FAIL muted_fall edge %0d: muted=%b, required %b", k, muted, (k < 4));
      end
    end
    repeat (1019) @(posedge clk);
    #1;
    checks++;
    if (dut.r_gain !== 9'd255) begin
      errors++;
      $display("FAIL gain_edge1023: gain=%0d, required 255", dut.r_gain);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.r_gain !== 9'd256) begin
      errors++;
      $display("FAIL gain_unity: gain=%0d, required 256", dut.r_gain);
    end
  endtask

  task automatic density_case(input logic [15:0] l, input logic [15:0] r, input logic [3:0] v,
                              input int lo_l, input int hi_l, input int lo_r, input int hi_r);
    int ones_l;
    int ones_r;
    vol = v;
    send_pair(l, r);
    repeat (6) @(posedge clk);
    ones_l = 0;
    ones_r = 0;
    repeat (4096) begin
      @(posedge clk);
      #1;
      ones_l += int'(al);
      ones_r += int'(ar);
    end
    checks++;
    if (ones_l < lo_l || ones_l > hi_l) begin
      errors++;
      $display("FAIL density_left %h vol %0d: ones=%0d, required %0d..%0d", l, v, ones_l, lo_l, hi_l);
    end
    checks++;
    if (ones_r < lo_r || ones_r > hi_r) begin
      errors++;
      $display("FAIL density_right %h vol %0d: ones=%0d, required %0d..%0d", r, v, ones_r, lo_r, hi_r);
    end
  endtask

  // Windows of 4096 clocks: expected ones = u/16.
  task automatic test_density();
    density_case(16'h0000, 16'h4000, 4'd0,  2048, 2048, 3072, 3072);
    density_case(16'h7FFF, 16'h8000, 4'd0,  4095, 4096,    0,    0);
    density_case(16'h8000, 16'h0000, 4'd0,     0,    0, 2048, 2048);
    density_case(16'h4000, 16'h7FFF, 4'd1,  2560, 2560, 3071, 3072);
    density_case(16'h4000, 16'h8000, 4'd15, 2048, 2048, 2047, 2048);
    vol = 4'd0;
  endtask

  task automatic test_handshake();
    int          accepts;
    logic        pre;
    logic [15:0] d;
    accepts = 0;
    d = 16'h1111;
    repeat (4) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pre   = ready;
      valid = 1'b1;
      if (pre) begin
        sl = d;
        sr = ~d;
        d  = d + 16'h1111;
        accepts++;
      end
      @(posedge clk);
      #1;
      checks++;
      if (ready !== !pre) begin
        errors++;
        $display("FAIL handshake_ready edge %0d: ready=%b, required %b", k, ready, !pre);
      end
    end
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if (accepts != 4) begin
      errors++;
      $display("FAIL handshake_accepts: accepts=%0d, required 4", accepts);
    end
  endtask

  task automatic test_latency();
    int ones;
    send_pair(16'h7FFF, 16'h7FFF);
    repeat (20) @(posedge clk);
    @(negedge clk);
    sl = 16'h8000; sr = 16'h8000; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (al !== 1'b0 || ar !== 1'b0) begin
      errors++;
      $display("FAIL latency_e3_down: left=%b right=%b, required 0 0", al, ar);
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    sl = 16'h7FFF; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (al !== 1'b0) begin
        errors++;
        $display("FAIL latency_early E+%0d: left=%b, required 0", k, al);
      end
    end
    ones = 0;
    repeat (16) begin
      @(posedge clk);
      #1 ones += int'(al);
    end
    checks++;
    if (ones < 15) begin
      errors++;
      $display("FAIL latency_new_value: ones=%0d of 16, required >=15", ones);
    end
  endtask

  task automatic test_mute_reversal();
    int bad;
    bad = 0;
    @(negedge clk);
    mute = 1'b1;
    repeat (400) begin
      @(posedge clk);
      #1 if (muted !== 1'b0) bad++;
    end
    checks++;
    if (dut.r_gain !== 9'd156) begin
      errors++;
      $display("FAIL mute_down: gain=%0d, required 156", dut.r_gain);
    end
    @(negedge clk);
    mute = 1'b0;
    repeat (200) begin
      @(posedge clk);
      #1 if (muted !== 1'b0) bad++;
    end
    checks++;
    if (dut.r_gain !== 9'd206) begin
      errors++;
      $display("FAIL mute_up_mid: gain=%0d, required 206", dut.r_gain);
    end
    repeat (200) begin
      @(posedge clk);
      #1 if (muted !== 1'b0) bad++;
    end
    checks++;
    if (dut.r_gain !== 9'd256) begin
      errors++;
      $display("FAIL mute_up_end: gain=%0d, required 256", dut.r_gain);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL muted_never: muted cycles=%0d, required 0", bad);
    end
  endtask

  task automatic test_async_reset();
    int ones_l;
    int ones_r;
    @(negedge clk);
    sl = 16'h7FFF; sr = 16'h7FFF; valid = 1'b1;
    @(posedge clk);
    #2;
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || al !== 1'b0 || ar !== 1'b0 || muted !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: ready=%b left=%b right=%b muted=%b, required 1 0 0 1",
               ready, al, ar, muted);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sl = 16'h0000; sr = 16'h0000;
    @(posedge clk);
    #1;
    checks++;
    if (muted !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_muted: muted=%b, required 1", muted);
    end
    ones_l = 0;
    ones_r = 0;
    repeat (1024) begin
      @(posedge clk);
      #1;
      ones_l += int'(al);
      ones_r += int'(ar);
    end
    checks++;
    if (ones_l != 512 || ones_r != 512) begin
      errors++;
      $display("FAIL post_reset_silence: left=%0d right=%0d, required 512 512", ones_l, ones_r);
    end
  endtask

  initial begin
    test_reset();
    test_density();
    test_handshake();
    test_latency();
    test_mute_reversal();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sd_audio_dac.md
# sd_audio_dac

Stereo audio output stage that takes the final mixed PCM sample pair and drives the two 1-bit audio pins. It accepts signed 16-bit samples over a valid/ready handshake and applies a click-free mute ramp and a coarse attenuation shift. It converts each channel to offset binary and modulates it with a first-order delta-sigma modulator running at the bus clock. It sits directly downstream of the sample mixer/saturation logic and replaces the per-channel bare DAC instances.

## Interface
- C_RAMP_DIV, 1024: clock cycles per mute-ramp gain step (≥2).
- Bus2IP_Clk  in  1  system clock; all logic on rising edge.
- Bus2IP_Resetn  in  1  reset, asynchronous, active-low.
- Sample_left  in  16  signed two's-complement left sample.
- Sample_right  in  16  signed two's-complement right sample.
- Sample_valid  in  1  sample pair present.
- Sample_ready  out  1  block can accept a pair this cycle.
- Mute  in  1  1 = ramp gain down to 0; 0 = ramp up to unity.
- Volume  in  4  attenuation, arithmetic right shift 0..15.
- Audio_left  out  1  left delta-sigma bitstream.
- Audio_right  out  1  right delta-sigma bitstream.
- Muted  out  1  1 while gain == 0.

## Operation
- Handshake: a pair is accepted on a rising edge where Sample_valid && Sample_ready. Sample_ready is a register.
  - The accepting edge clears Sample_ready and loads the pair into the hold registers.
  - The next edge copies hold into the active registers and sets Sample_ready.
  - Throughput is at most one pair per 2 clocks.
  - While Sample_ready=0, Sample_valid is ignored. The upstream stage must hold the data stable until the accept edge.
- Active registers keep their value until the next pair arrives (zero-order hold). Underrun repeats the last sample.
- Gain: 9-bit unsigned register, range 0..256, where 256 = unity.
  - Ramp counter: free-running 0..C_RAMP_DIV-1, wraps.
  - On each terminal count: if Mute=1 and gain>0, gain−1. If Mute=0 and gain<256, gain+1. Otherwise hold.
  - Toggling Mute mid-ramp reverses direction from the current gain. There is no restart.
- Scaling per channel:
  - p = (active × gain) as signed 25-bit.
  - s = (p >>> 8)[15:0].
  - v = s >>> Volume (arithmetic; Volume=15 gives 0 or −1).
  - u = v ^ 16'h8000.
  - No overflow is possible: the range of s is −32768..32767.
- Modulator per channel: 17-bit acc.
  - Each clock, acc ← {1'b0, acc[15:0]} + u.
  - Audio_x = acc[16] (registered).
  - Ones density equals u/65536. Silence (u=0x8000) gives a 50% pattern.
- Muted = (gain == 0), combinational from the gain register.
- Volume and Mute are sampled every clock. There is no handshake on them.

## Timing
- Reset values, applied asynchronously on Bus2IP_Resetn=0:
  - Sample_ready=1, Audio_left=Audio_right=0, Muted=1.
  - gain=0, ramp counter=0, hold/active registers=0, scaled u registers=16'h8000, accumulators=0.
- Pipeline: accept edge E → active at E+1 → u register at E+2 → accumulator/Audio bit at E+3. A new sample first affects the output bit at edge E+3.
- Gain or Volume changes reach the u register on the next edge, and the output one edge later.
- After reset release, gain reaches 256 after 256×C_RAMP_DIV cycles if Mute=0. Muted falls at the first terminal count.
- Reset asserted mid-stream immediately forces all reset values. Any in-flight pair is lost.
- Sample_valid asserted during reset: not accepted. The first accept can occur on the first edge after release.

## Test plan
- Reset/ramp, C_RAMP_DIV=4, Mute=0: during reset, outputs 0, Muted=1, Sample_ready=1. After release, Muted=0 at the 4th edge; gain=256 after 1024 cycles.
- Density check at unity gain, Volume=0, over 65536 clocks after settling:
  - left=16'h0000 → 32768 ones.
  - 16'h7FFF → 65535 ones.
  - 16'h8000 → 0 ones.
  - Right channel is independent: 16'h4000 → 49152 ones.
- Volume=1 with left=16'h4000 → u=16'hA000 → 40960 ones/65536. Volume=15 with 16'h4000 → 32768 ones.
- Handshake: Sample_valid held high with a new pair each accept → accepts on alternate edges, Sample_ready low exactly one cycle after each accept. A changed bit in the pair appears on the Audio pattern at E+3.
- Mute reversal, C_RAMP_DIV=4, gain 256:
  - Assert Mute for 400 cycles → gain 156.
  - Deassert → gain rises from 156 and reaches 256 after 400 more cycles.
  - Muted never asserts.
- Mid-stream async reset: assert Bus2IP_Resetn=0 between edges → outputs go to reset values without waiting for a clock edge. After release, 16'h8000-offset silence gives 50% density once the ramp starts.
